// File: rtl/reduce_arb_mux.sv
// reduce_arb_mux: N-input priority arbiter with per-input FIFOs and a 3-stage reduction pipeline.
// Define RR_TIEBREAK_EN for round-robin tie-breaking among equal-priority heads (default: lowest index wins).

module reduce_arb_mux_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] din,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty
);
  // Depth must be a power of two and at least 2; pointers carry one extra wrap bit.
  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [Width-1:0] mem [Depth];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             do_push;
  logic             do_pop;

  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty   = (wp == rp);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rp[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + PtrOne;
      if (do_pop)  rp <= rp + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end
endmodule

module reduce_arb_mux #(
  parameter int NumPorts        = 7,
  parameter int DataWidth       = 256,
  parameter int ReductionBitPos = 254,
  parameter int PayloadLen      = 128,
  parameter int IndexPos        = 128,
  parameter int IndexWidth      = 16,
  parameter int WeightPos       = 144,
  parameter int WeightWidth     = 8,
  parameter int PriorityPos     = 152,
  parameter int PriorityWidth   = 8,
  parameter int FaninPos        = 164,
  parameter int FIFODepth       = 4,
  parameter int TableAddrWidth  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NumPorts*DataWidth-1:0] in_data,
  output logic [NumPorts-1:0]           in_avail,
  input  logic                          out_stall,
  output logic [DataWidth-1:0]          out
);
  localparam int TableSize = 1 << TableAddrWidth;
  localparam int PortW     = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int AddrBits  = (TableAddrWidth < IndexWidth) ? TableAddrWidth : IndexWidth;

  typedef logic [DataWidth-1:0] pkt_t;

  typedef struct packed {
    logic [2:0]             expect_cnt;
    logic [2:0]             arrived;
    logic [WeightWidth-1:0] weight_acc;
    logic [PayloadLen-1:0]  payload_acc;
  } entry_t;

  pkt_t                head [NumPorts];
  logic [NumPorts-1:0] full;
  logic [NumPorts-1:0] empty;
  logic [NumPorts-1:0] pop;
  logic                advance;

  assign advance  = !out_stall;
  assign in_avail = ~full;

  for (genvar k = 0; k < NumPorts; k++) begin : g_fifo
    reduce_arb_mux_fifo #(
      .Width(DataWidth),
      .Depth(FIFODepth)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (in_data[k*DataWidth + DataWidth - 1]),
      .din  (in_data[k*DataWidth +: DataWidth]),
      .pop  (pop[k]),
      .head (head[k]),
      .full (full[k]),
      .empty(empty[k])
    );
  end

  // ---------------- arbitration ----------------
  logic [PortW-1:0]         win;
  logic                     win_vld;
  logic [PriorityWidth-1:0] best_pri;

`ifdef RR_TIEBREAK_EN
  logic [PortW-1:0] rr_ptr;
`endif

  // Scan order starts at the tie-break origin; strict '>' keeps the first-scanned head on ties.
  always_comb begin
    int               p;
    logic [PortW-1:0] pi;
    p        = 0;
    pi       = '0;
    win      = '0;
    win_vld  = 1'b0;
    best_pri = '0;
    for (int j = 0; j < NumPorts; j++) begin
`ifdef RR_TIEBREAK_EN
      p = int'(rr_ptr) + j;
      if (p >= NumPorts) p = p - NumPorts;
`else
      p = j;
`endif
      pi = PortW'(p);
      if (!empty[pi] && (!win_vld || (head[pi][PriorityPos +: PriorityWidth] > best_pri))) begin
        win_vld  = 1'b1;
        win      = pi;
        best_pri = head[pi][PriorityPos +: PriorityWidth];
      end
    end
  end

  always_comb begin
    pop = '0;
    if (advance && win_vld) pop[win] = 1'b1;
  end

`ifdef RR_TIEBREAK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (advance && win_vld) begin
      rr_ptr <= (win == PortW'(NumPorts - 1)) ? '0 : win + PortW'(1);
    end
  end
`endif

  // ---------------- pipeline FR -> RR -> WB ----------------
  pkt_t                      fr_q;
  pkt_t                      rr_q;
  logic                      rd_vld;
  entry_t                    rd_ent;
  logic [TableSize-1:0]      tbl_vld;
  entry_t                    tbl_mem [TableSize];
  logic [TableAddrWidth-1:0] fr_idx;
  logic [TableAddrWidth-1:0] rr_idx;
  logic                      fr_red;
  logic                      rr_red;

  assign fr_idx = TableAddrWidth'(fr_q[IndexPos +: AddrBits]);
  assign rr_idx = TableAddrWidth'(rr_q[IndexPos +: AddrBits]);
  assign fr_red = fr_q[DataWidth-1] && fr_q[ReductionBitPos];
  assign rr_red = rr_q[DataWidth-1] && rr_q[ReductionBitPos];

  logic [2:0]             fanin;
  logic [2:0]             exp_cnt;
  logic [2:0]             arr_cnt;
  logic [3:0]             arr_next;
  logic [WeightWidth-1:0] w_base;
  logic [WeightWidth-1:0] w_new;
  logic [PayloadLen-1:0]  p_base;
  logic [PayloadLen-1:0]  p_new;
  logic                   done;
  entry_t                 nxt_ent;
  logic                   nxt_vld;
  pkt_t                   out_nxt;

  always_comb begin
    fanin = rr_q[FaninPos +: 3];
    if (rd_vld) begin
      exp_cnt = rd_ent.expect_cnt;
      arr_cnt = rd_ent.arrived;
      w_base  = rd_ent.weight_acc;
      p_base  = rd_ent.payload_acc;
    end else begin
      exp_cnt = (fanin == 3'd0) ? 3'd1 : fanin;
      arr_cnt = 3'd0;
      w_base  = '0;
      p_base  = '0;
    end
    arr_next = {1'b0, arr_cnt} + 4'd1;
    w_new    = w_base + rr_q[WeightPos +: WeightWidth];
    p_new    = p_base + rr_q[PayloadLen-1:0];
    done     = (arr_next >= {1'b0, exp_cnt});

    nxt_ent.expect_cnt  = exp_cnt;
    nxt_ent.arrived     = arr_next[2:0];
    nxt_ent.weight_acc  = w_new;
    nxt_ent.payload_acc = p_new;
    nxt_vld             = !done;

    out_nxt = '0;
    if (rr_q[DataWidth-1] && !rr_q[ReductionBitPos]) begin
      out_nxt = rr_q;
    end else if (rr_red && done) begin
      out_nxt                             = rr_q;
      out_nxt[WeightPos +: WeightWidth]   = w_new;
      out_nxt[PayloadLen-1:0]             = p_new;
    end
  end

  // A WB update to the idx being read this edge is not yet visible in the table, so bypass it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fr_q    <= '0;
      rr_q    <= '0;
      out     <= '0;
      rd_vld  <= 1'b0;
      rd_ent  <= '0;
      tbl_vld <= '0;
    end else if (advance) begin
      fr_q <= win_vld ? head[win] : '0;
      rr_q <= fr_q;
      out  <= out_nxt;
      if (rr_red) tbl_vld[rr_idx] <= nxt_vld;
      if (rr_red && fr_red && (rr_idx == fr_idx)) begin
        rd_vld <= nxt_vld;
        rd_ent <= nxt_ent;
      end else begin
        rd_vld <= tbl_vld[fr_idx];
        rd_ent <= tbl_mem[fr_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance && rr_red && nxt_vld) tbl_mem[rr_idx] <= nxt_ent;
  end
endmodule

// File: tb/tb_reduce_arb_mux.sv
// Directed bench for reduce_arb_mux: latency, priority, tie-break, reduction, wrap, stall and reset.
module tb_reduce_arb_mux;
  localparam int NP = 7;
  localparam int DW = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP*DW-1:0]  in_data;
  logic [NP-1:0]     in_avail;
  logic              out_stall;
  logic [DW-1:0]     out;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] got [$];

  always #5 clk = ~clk;

  reduce_arb_mux dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_avail (in_avail),
    .out_stall(out_stall),
    .out      (out)
  );

  function automatic logic [DW-1:0] mk(input logic red, input logic [7:0] pri, input logic [15:0] idx,
                                       input logic [7:0] wt, input logic [2:0] fan, input logic [127:0] pay);
    logic [DW-1:0] p;
    p            = '0;
    p[255]       = 1'b1;
    p[254]       = red;
    p[127:0]     = pay;
    p[143:128]   = idx;
    p[151:144]   = wt;
    p[159:152]   = pri;
    p[166:164]   = fan;
    return p;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    in_data   = '0;
    out_stall = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic push1(input int port, input logic [DW-1:0] p);
    in_data = '0;
    in_data[port*DW +: DW] = p;
    step(1);
    in_data = '0;
  endtask

  task automatic collect(input int n);
    got.delete();
    repeat (n) begin
      @(negedge clk);
      if (out[DW-1]) got.push_back(out);
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] p;
    apply_reset();
    checks++; if (out !== '0) begin errors++; $display("FAIL reset_out got %h want 0", out); end
    checks++; if (in_avail !== 7'h7f) begin errors++; $display("FAIL reset_avail got %h want 7f", in_avail); end
    p = mk(1'b0, 8'd1, 16'h0, 8'h0, 3'd0, 128'hABC);
    push1(0, p);
    step(3);
    checks++; if (out !== p) begin errors++; $display("FAIL pre_reset_out got %h want %h", out, p); end
    #1 rst = 1'b1;
    #1;
    checks++; if (out !== '0) begin errors++; $display("FAIL async_reset_out got %h want 0", out); end
    step(1);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_plain_latency();
    logic [DW-1:0] p;
    p = mk(1'b0, 8'd5, 16'h77, 8'h3, 3'd0, 128'h1234_5678);
    apply_reset();
    push1(3, p);
    for (int i = 0; i < 3; i++) begin
      checks++; if (out !== '0) begin errors++; $display("FAIL plain_early c%0d got %h want 0", i, out); end
      step(1);
    end
    checks++; if (out !== p) begin errors++; $display("FAIL plain_out got %h want %h", out, p); end
    step(1);
    checks++; if (out !== '0) begin errors++; $display("FAIL plain_after got %h want 0", out); end
  endtask

  task automatic test_priority();
    logic [DW-1:0] pa;
    logic [DW-1:0] pb;
    pa = mk(1'b0, 8'd9, 16'h0, 8'h0, 3'd0, 128'h111);
    pb = mk(1'b0, 8'd2, 16'h0, 8'h0, 3'd0, 128'h444);
    apply_reset();
    in_data = '0;
    in_data[1*DW +: DW] = pa;
    in_data[4*DW +: DW] = pb;
    step(1);
    in_data = '0;
    collect(8);
    checks++; if (got.size() != 2) begin errors++; $display("FAIL prio_count got %0d want 2", got.size()); end
    checks++; if (got.size() < 1 || got[0] !== pa) begin errors++; $display("FAIL prio_first want %h", pa); end
    checks++; if (got.size() < 2 || got[1] !== pb) begin errors++; $display("FAIL prio_second want %h", pb); end
  endtask

  task automatic test_tie();
`ifdef RR_TIEBREAK_EN
    int ord_p[6] = '{0, 2, 5, 0, 2, 5};
    int ord_s[6] = '{0, 0, 0, 1, 1, 1};
`else
    int ord_p[6] = '{0, 0, 2, 2, 5, 5};
    int ord_s[6] = '{0, 1, 0, 1, 0, 1};
`endif
    logic [DW-1:0] e;
    apply_reset();
    for (int s = 0; s < 2; s++) begin
      in_data = '0;
      in_data[0*DW +: DW] = mk(1'b0, 8'd7, 16'h0, 8'h0, 3'd0, 128'(0 * 16 + s));
      in_data[2*DW +: DW] = mk(1'b0, 8'd7, 16'h0, 8'h0, 3'd0, 128'(2 * 16 + s));
      in_data[5*DW +: DW] = mk(1'b0, 8'd7, 16'h0, 8'h0, 3'd0, 128'(5 * 16 + s));
      step(1);
    end
    in_data = '0;
    collect(12);
    checks++; if (got.size() != 6) begin errors++; $display("FAIL tie_count got %0d want 6", got.size()); end
    for (int i = 0; i < 6; i++) begin
      e = mk(1'b0, 8'd7, 16'h0, 8'h0, 3'd0, 128'(ord_p[i] * 16 + ord_s[i]));
      checks++;
      if (i >= got.size() || got[i] !== e) begin
        errors++; $display("FAIL tie_order pos %0d want port %0d seq %0d", i, ord_p[i], ord_s[i]);
      end
    end
  endtask

  task automatic test_reduction();
    logic [DW-1:0] e;
    apply_reset();
    push1(0, mk(1'b1, 8'd6, 16'h12, 8'd1, 3'd3, 128'd1));
    push1(0, mk(1'b1, 8'd6, 16'h12, 8'd1, 3'd3, 128'd2));
    push1(0, mk(1'b1, 8'd6, 16'h12, 8'd1, 3'd3, 128'd3));
    step(1);
    checks++; if (out !== '0) begin errors++; $display("FAIL red_partial1 got %h want 0", out); end
    step(1);
    checks++; if (out !== '0) begin errors++; $display("FAIL red_partial2 got %h want 0", out); end
    step(1);
    e = mk(1'b1, 8'd6, 16'h12, 8'd3, 3'd3, 128'd6);
    checks++; if (out !== e) begin errors++; $display("FAIL red_result got %h want %h", out, e); end
    step(1);
    checks++; if (out !== '0) begin errors++; $display("FAIL red_after got %h want 0", out); end
    // entry must have retired: a fan-in-1 contribution completes alone with its own values
    push1(2, mk(1'b1, 8'd6, 16'h12, 8'd2, 3'd1, 128'd9));
    collect(6);
    e = mk(1'b1, 8'd6, 16'h12, 8'd2, 3'd1, 128'd9);
    checks++; if (got.size() != 1 || got[0] !== e) begin errors++; $display("FAIL red_retired n=%0d want %h", got.size(), e); end
  endtask

  task automatic test_wrap_fanin0();
    logic [DW-1:0] e;
    logic [127:0]  ones;
    ones = {128{1'b1}};
    apply_reset();
    push1(2, mk(1'b1, 8'd1, 16'h40, 8'hFF, 3'd2, ones));
    push1(2, mk(1'b1, 8'd1, 16'h40, 8'h02, 3'd2, 128'd1));
    collect(8);
    e = mk(1'b1, 8'd1, 16'h40, 8'h01, 3'd2, 128'd0);
    checks++; if (got.size() != 1 || got[0] !== e) begin errors++; $display("FAIL wrap_result n=%0d want %h", got.size(), e); end
    e = mk(1'b1, 8'd1, 16'h41, 8'h05, 3'd0, 128'h77);
    push1(4, e);
    step(3);
    checks++; if (out !== e) begin errors++; $display("FAIL fanin0_out got %h want %h", out, e); end
  endtask

  task automatic test_stall();
    logic [DW-1:0] x;
    int cnt[NP][4];
    int bad;
    int v;
    x = mk(1'b0, 8'd3, 16'h0, 8'h0, 3'd0, 128'hF00D);
    apply_reset();
    push1(6, x);
    step(3);
    checks++; if (out !== x) begin errors++; $display("FAIL stall_pre got %h want %h", out, x); end
    out_stall = 1'b1;
    for (int s = 0; s < 4; s++) begin
      in_data = '0;
      for (int k = 0; k < NP; k++) in_data[k*DW +: DW] = mk(1'b0, 8'(k), 16'h0, 8'h0, 3'd0, 128'(k * 16 + s));
      step(1);
    end
    in_data = '0;
    for (int c = 0; c < 5; c++) begin
      checks++; if (in_avail !== '0) begin errors++; $display("FAIL stall_avail c%0d got %h want 0", c, in_avail); end
      checks++; if (out !== x) begin errors++; $display("FAIL stall_hold c%0d got %h want %h", c, out, x); end
      step(1);
    end
    out_stall = 1'b0;
    collect(45);
    for (int k = 0; k < NP; k++) for (int s = 0; s < 4; s++) cnt[k][s] = 0;
    bad = 0;
    for (int i = 0; i < got.size(); i++) begin
      v = int'(got[i][31:0]);
      if ((v / 16) < NP && (v % 16) < 4) cnt[v / 16][v % 16]++;
      else bad++;
    end
    for (int k = 0; k < NP; k++) for (int s = 0; s < 4; s++) if (cnt[k][s] != 1) bad++;
    checks++; if (got.size() != 28) begin errors++; $display("FAIL stall_count got %0d want 28", got.size()); end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_lossdup bad %0d want 0", bad); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] e;
    apply_reset();
    push1(0, mk(1'b1, 8'd4, 16'h33, 8'd1, 3'd3, 128'd5));
    step(4);
    push1(3, mk(1'b0, 8'd4, 16'h0, 8'h0, 3'd0, 128'hDEAD));
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    push1(0, mk(1'b1, 8'd4, 16'h33, 8'd1, 3'd2, 128'd7));
    push1(0, mk(1'b1, 8'd4, 16'h33, 8'd1, 3'd2, 128'd1));
    collect(8);
    e = mk(1'b1, 8'd4, 16'h33, 8'd2, 3'd2, 128'd8);
    checks++; if (got.size() != 1) begin errors++; $display("FAIL rstmid_count got %0d want 1", got.size()); end
    checks++; if (got.size() < 1 || got[0] !== e) begin errors++; $display("FAIL rstmid_result want %h", e); end
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    out_stall = 1'b0;
    test_reset();
    test_plain_latency();
    test_priority();
    test_tie();
    test_reduction();
    test_wrap_fanin0();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reduce_arb_mux.md
# reduce_arb_mux

Parametrised N-input priority arbiter with in-network reduction, the output multiplexer of one switch output port. Each input has its own FIFO. The highest-priority FIFO head is selected each cycle. Plain packets are forwarded. Reduction packets are accumulated in an indexed reduction table and emitted only once all expected contributions have arrived. Compared with the fixed 7-port generation, this block adds a configurable port count, output backpressure, per-entry fan-in taken from the packet, read-after-write forwarding, and entry retirement.

## Interface
Parameters:
- NumPorts, 7: number of input channels (2..16).
- DataWidth, 256: packet width; bit DataWidth-1 is the valid flag.
- ReductionBitPos, 254: set marks a reduction packet.
- PayloadLen, 128: payload field [PayloadLen-1:0].
- IndexPos / IndexWidth, 128 / 16: reduction index field.
- WeightPos / WeightWidth, 144 / 8: weight field.
- PriorityPos / PriorityWidth, 152 / 8: priority field; larger value wins.
- FaninPos, 164: 3-bit expected contribution count field.
- FIFODepth, 4: per-input FIFO depth (power of 2).
- TableAddrWidth, 8: table has 2^TableAddrWidth entries, addressed by the low bits of the index.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- in_data  in  NumPorts*DataWidth  packed input packets; port k occupies [k*DataWidth +: DataWidth].
- in_avail  out  NumPorts  bit k = FIFO k not full.
- out_stall  in  1  downstream cannot accept; freezes the pipeline.
- out  out  DataWidth  output packet register; valid when out[DataWidth-1]=1.

## Operation
- **Enqueue:** port k writes when in_data valid bit is 1 and in_avail[k] is 1. A write into a full FIFO is dropped; honouring in_avail is the sender's responsibility.
- **Stage FR (arbitration):**
  - Among non-empty FIFOs, pick the maximum priority. Empty FIFOs never win.
  - On a tie, the winner depends on the RR_TIEBREAK_EN configuration.
  - The winner is dequeued into register fr_q. If no FIFO is non-empty, fr_q is loaded invalid (all zero).
- **Stage RR (table read):** fr_q moves to rr_q. For a valid reduction packet, table entry T[idx] is read, where idx = low TableAddrWidth bits of the index field.
- **Entry format:** {valid, expect[2:0], arrived[2:0], weight_acc[WeightWidth-1:0], payload_acc[PayloadLen-1:0]}.
- **Forwarding:** if the packet in WB targets the same idx in the same cycle, WB's next-entry value is used instead of the RAM read.
- **Stage WB (write-back):**
  - Plain valid packet: out <= rr_q.
  - Reduction packet: if the entry is invalid, it is treated as expect = packet fan-in (0 treated as 1), arrived = 0, accumulators = 0.
  - Accumulation: weight_acc += weight (mod 2^WeightWidth); payload_acc += payload (mod 2^PayloadLen); arrived += 1.
  - Completion: if arrived+1 >= expect, out <= {rr_q bits above PriorityPos+PriorityWidth-1, rr_q priority, weight_acc_new, index, payload_acc_new}, and the entry valid bit is cleared.
  - Otherwise the updated entry is written back with valid=1, and out <= 0.
  - An invalid rr_q gives out <= 0.
- **Backpressure:** out_stall=1 holds fr_q, rr_q, out and the table unchanged, and performs no dequeue. Enqueue continues.

## Timing
- Latency: FIFO head to out is 3 cycles when unstalled. A packet written at edge t is eligible from cycle t+1.
- Throughput: 1 packet/cycle, including back-to-back reductions to the same idx (via forwarding).
- Reset (async): FIFOs empty, in_avail all 1, fr_q = rr_q = out = 0, all table valid bits 0, round-robin pointer = 0. Payload RAM contents are don't-care.
- Reset asserted mid-operation discards all in-flight packets and partial reductions.
- Simultaneous enqueue and dequeue on a full FIFO: the dequeue frees a slot, but in_avail was 0, so the write is not expected. Enqueue and dequeue on a 1-entry FIFO are legal in the same cycle.

## Configuration
- RR_TIEBREAK_EN defined: among equal-priority winners, the lowest port index ≥ rr_ptr wins (wrapping). rr_ptr <= winner+1 mod NumPorts after each dequeue.
- RR_TIEBREAK_EN undefined: the lowest port index always wins ties. No pointer is implemented.

## Test plan
- Plain packet on port 3, priority 5, others idle -> appears on out exactly 3 cycles after it reaches the FIFO head, unchanged.
- Ports 1 (priority 9) and 4 (priority 2) both loaded -> port 1 emitted first, then port 4.
- Equal priority 7 on ports 0, 2, 5, two packets each -> with RR_TIEBREAK_EN the order is 0,2,5,0,2,5; without it, 0,0,2,2,5,5.
- Three reduction packets, idx 0x12, fan-in 3, payloads 1,2,3, weights 1,1,1, sent back-to-back -> out=0 twice, then one packet with payload 6, weight 3, and entry 0x12 invalid afterwards.
- Payload all-ones + 1, fan-in 2 -> payload wraps to 0. Fan-in 0 -> emitted immediately.
- out_stall held 5 cycles with all FIFOs full -> out constant and in_avail all 0. After release, no loss or duplication. Reset mid-reduction -> the next contribution starts a fresh entry.
